// File: rtl/sccb_pkg.sv
// Shared types and constants for the SCCB master: FSM states, byte-select phases,
// quarter index and the line levels each symbol starts with.
package sccb_pkg;

  localparam int unsigned CMD_W  = 16;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned SYM_WR = 30;
  localparam int unsigned SYM_RD = 42;

  typedef logic [1:0] quarter_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_TX,
    ST_TXACK,
    ST_RX,
    ST_RXNA,
    ST_STOP,
    ST_BUSFREE
  } state_t;

  // Byte order on the wire; the numeric order matters because TXACK steps phase+1.
  typedef enum logic [1:0] {
    PH_ID_W,
    PH_ADDR,
    PH_DATA,
    PH_ID_R
  } phase_t;

  typedef struct packed {
    logic scl;
    logic sda_low;
  } line_t;

  function automatic logic [BYTE_W-1:0] sel_byte(phase_t p, logic [BYTE_W-1:0] dev_id,
                                                 logic [CMD_W-1:0] cmd);
    logic [BYTE_W-1:0] b;
    b = dev_id;
    case (p)
      PH_ADDR: b = cmd[15:8];
      PH_DATA: b = cmd[7:0];
      PH_ID_R: b = dev_id | 8'h01;
      default: b = dev_id;
    endcase
    return b;
  endfunction

  // Line levels during q0 of a symbol; b is the data bit for TX symbols.
  function automatic line_t q0_lines(state_t s, logic b);
    line_t l;
    l.scl     = 1'b0;
    l.sda_low = 1'b0;
    case (s)
      ST_TX:                         l.sda_low = ~b;
      ST_STOP:                       l.sda_low = 1'b1;
      ST_START, ST_BUSFREE, ST_IDLE: l.scl     = 1'b1;
      default:                       ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/sccb_if.sv
// Command handshake between the init sequencer and the SCCB master.
interface sccb_if;
  import sccb_pkg::*;

  logic              start;
  logic              r_w;
  logic [CMD_W-1:0]  in_data;
  logic              load_comp;
  logic              task_comp;
  logic [BYTE_W-1:0] data_read;
  logic              nack;

  modport master (input start, r_w, in_data, output load_comp, task_comp, data_read, nack);
  modport slave  (output start, r_w, in_data, input load_comp, task_comp, data_read, nack);
endinterface

// File: rtl/sccb_tick_gen.sv
// Quarter-period divider: tick is high on the last clk of each quarter, q counts quarters.
module sccb_tick_gen
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250
) (
  input  logic     clk,
  input  logic     rst,
  input  logic     clr,
  output logic     tick,
  output quarter_t q
);

  localparam int unsigned CW = $clog2(CLK_DIV);

  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt_c;

  always_comb begin
    cnt_nxt_c = cnt + CW'(1);
    if (cnt == CW'(CLK_DIV - 1)) cnt_nxt_c = '0;
  end

  // tick is registered against the value cnt is about to take.
  always_ff @(posedge clk) begin
    if (!rst || clr) begin
      cnt  <= '0;
      tick <= 1'b0;
      q    <= '0;
    end else begin
      cnt  <= cnt_nxt_c;
      tick <= (cnt_nxt_c == CW'(CLK_DIV - 1));
      if (tick) q <= q + 2'd1;
    end
  end

endmodule

// File: rtl/sccb_master.sv
// Bit-level SCCB master: one 16-bit command per transaction, 3-phase write or
// 2-phase write followed by 2-phase read, SCL derived from clk via sccb_tick_gen.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int unsigned CLK_DIV = 250,
  parameter logic [7:0]  DEV_ID  = 8'h42
) (
  input  logic   clk,
  input  logic   rst,
  sccb_if.master bus,
  inout  wire    SDA,
  output logic   SCL
);

  state_t            state;
  phase_t            phase;
  phase_t            next_ph_c;
  logic [2:0]        bit_cnt;
  logic [BYTE_W-1:0] tx_sr;
  logic [BYTE_W-1:0] rx_sr;
  logic [BYTE_W-1:0] tx_byte_c;
  logic [CMD_W-1:0]  cmd;
  logic              rd;
  line_t             line;
  logic              tick;
  quarter_t          q;
  logic              accept_c;

  assign accept_c  = (state == ST_IDLE) && bus.start;
  assign next_ph_c = phase_t'(phase + 2'd1);
  assign tx_byte_c = sel_byte((state == ST_START) ? phase : next_ph_c, DEV_ID, cmd);

  assign SCL = line.scl;
  assign SDA = line.sda_low ? 1'b0 : 1'bz;

  sccb_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (accept_c),
    .tick (tick),
    .q    (q)
  );

  // Line levels are updated at quarter boundaries with the values of the quarter being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= ST_IDLE;
      phase         <= PH_ID_W;
      bit_cnt       <= '0;
      tx_sr         <= '0;
      rx_sr         <= '0;
      cmd           <= '0;
      rd            <= 1'b0;
      line          <= q0_lines(ST_IDLE, 1'b0);
      bus.load_comp <= 1'b0;
      bus.task_comp <= 1'b0;
      bus.data_read <= '0;
      bus.nack      <= 1'b0;
    end else begin
      bus.load_comp <= 1'b0;
      bus.task_comp <= 1'b0;
      if (accept_c) begin
        cmd           <= bus.in_data;
        rd            <= bus.r_w;
        bus.nack      <= 1'b0;
        phase         <= PH_ID_W;
        state         <= ST_START;
        line          <= q0_lines(ST_START, 1'b0);
        bus.load_comp <= 1'b1;
      end else if (state != ST_IDLE && tick) begin
        case (q)
          2'd1: begin
            line.scl <= 1'b1;
            if (state == ST_START) line.sda_low <= 1'b1;
          end
          2'd2: begin
            if (state == ST_TXACK && SDA) bus.nack <= 1'b1;
            if (state == ST_RX) rx_sr <= {rx_sr[6:0], SDA};
            if (state == ST_STOP) line.sda_low <= 1'b0;
          end
          2'd3: begin
            case (state)
              ST_START: begin
                state   <= ST_TX;
                bit_cnt <= '0;
                tx_sr   <= tx_byte_c;
                line    <= q0_lines(ST_TX, tx_byte_c[7]);
              end
              ST_TX: begin
                if (bit_cnt == 3'd7) begin
                  state <= ST_TXACK;
                  line  <= q0_lines(ST_TXACK, 1'b0);
                end else begin
                  bit_cnt <= bit_cnt + 3'd1;
                  tx_sr   <= {tx_sr[6:0], 1'b0};
                  line    <= q0_lines(ST_TX, tx_sr[6]);
                end
              end
              ST_TXACK: begin
                if (phase == PH_ID_R) begin
                  state   <= ST_RX;
                  bit_cnt <= '0;
                  line    <= q0_lines(ST_RX, 1'b0);
                end else if (phase == PH_DATA || (phase == PH_ADDR && rd)) begin
                  state <= ST_STOP;
                  line  <= q0_lines(ST_STOP, 1'b0);
                end else begin
                  phase   <= next_ph_c;
                  state   <= ST_TX;
                  bit_cnt <= '0;
                  tx_sr   <= tx_byte_c;
                  line    <= q0_lines(ST_TX, tx_byte_c[7]);
                end
              end
              ST_RX: begin
                line <= q0_lines(ST_RX, 1'b0);
                if (bit_cnt == 3'd7) state <= ST_RXNA;
                else bit_cnt <= bit_cnt + 3'd1;
              end
              ST_RXNA: begin
                state <= ST_STOP;
                line  <= q0_lines(ST_STOP, 1'b0);
              end
              ST_STOP: begin
                state <= ST_BUSFREE;
                line  <= q0_lines(ST_BUSFREE, 1'b0);
              end
              ST_BUSFREE: begin
                line <= q0_lines(ST_START, 1'b0);
                if (rd && phase == PH_ADDR) begin
                  phase <= PH_ID_R;
                  state <= ST_START;
                end else begin
                  state         <= ST_IDLE;
                  bus.task_comp <= 1'b1;
                  if (rd) bus.data_read <= rx_sr;
                end
              end
              default: state <= ST_IDLE;
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: doc/sccb_master.md
# sccb_master

- Bit-level SCCB (I2C-compatible) master serving the OV7670 init sequencer.
- Accepts one 16-bit register command at a time and performs either a 3-phase write or a 2-phase-write-plus-2-phase-read on SCL/SDA.
- Reports command capture with `load_comp` and transaction end with `task_comp`.
- Uses a single system clock; SCL is derived internally, so no separate SCCB clock is needed.

## Interface
Parameters:
- `CLK_DIV`, default 250: clk cycles per SCL quarter-period. Minimum 2. At 50 MHz, 250 gives a 50 kHz SCL.
- `DEV_ID`, default 8'h42: camera write ID. The read ID is `DEV_ID | 1`.

Ports:
- `clk`  in  1  system clock. All logic is on the rising edge.
- `rst`  in  1  reset. Synchronous, active-low.
- `start`  in  1  command request. Sampled only in IDLE.
- `r_w`  in  1  0 = write, 1 = read. Captured with `start`.
- `in_data`  in  16  [15:8] register address, [7:0] write data (ignored for reads).
- `load_comp`  out  1  one-cycle pulse: command captured.
- `task_comp`  out  1  one-cycle pulse: transaction finished, bus free.
- `data_read`  out  8  last byte read. Updated only at the end of a read.
- `nack`  out  1  any slave X/ACK bit sampled high in the current transaction.
- `SDA`  inout  1  open-drain: drives 0 or releases (Z). External pull-up.
- `SCL`  out  1  push-pull clock. Idle high.

## Operation
**Quarter tick.** Divider emits a tick every `CLK_DIV` cycles and advances quarter index q = 0..3. A symbol is 4 quarters.

**Symbols:**
- START: q0–q1 SDA=Z, SCL=1; q2–q3 SDA=0, SCL=1.
- BIT: q0–q1 SCL=0, SDA set at q0 entry; q2–q3 SCL=1. Sample SDA on the last clk of q2.
- STOP: q0–q1 SCL=0, SDA=0; q2 SCL=1, SDA=0; q3 SCL=1, SDA=Z.
- BUSFREE: SCL=1, SDA=Z.

**State machine:** IDLE, START, TX (8 bits, MSB first), TXACK (release SDA, sample X), RX (release SDA, shift in MSB first), RXNA (drive SDA=Z, i.e. 1), STOP, BUSFREE.
- A phase counter selects the byte order:
  - Write: `DEV_ID`, addr, data.
  - Read phase 1: `DEV_ID`, addr.
  - Read phase 2: `DEV_ID|1`, then RX.
- Write sequence: START, TX/TXACK ×3, STOP, BUSFREE → IDLE. Total 30 symbols.
- Read sequence: START, TX/TXACK ×2, STOP, BUSFREE, START, TX/TXACK (`DEV_ID|1`), RX, RXNA, STOP, BUSFREE → IDLE. Total 42 symbols.

**Acceptance:**
- In IDLE with `start`=1, latch `r_w` and `in_data`, clear `nack`, reset the divider, and go to START.
- `load_comp`=1 in the following cycle only.
- `start` outside IDLE is ignored.

**Results:**
- `nack` is set on any TXACK sample of 1. It is informational only: the transaction always runs to completion.
- `data_read` is loaded from the RX shift register on the cycle `task_comp` is high, and held otherwise.

**Reset values:** SCL=1, SDA=Z, `load_comp`=0, `task_comp`=0, `data_read`=8'h00, `nack`=0, state IDLE, divider 0.

**Reset mid-transaction:** abort on the next clk edge, release both lines, no `task_comp`. The slave may observe a truncated frame; this is accepted.

## Timing
- `load_comp` pulses 1 cycle after `start` is sampled in IDLE. Symbol 0 begins in that same cycle.
- `task_comp` pulses exactly 30·4·`CLK_DIV` cycles after the `load_comp` cycle for a write, and 42·4·`CLK_DIV` for a read.
- `task_comp` is asserted in the cycle the FSM re-enters IDLE. `start` high in that same cycle is accepted, giving `load_comp` on the next cycle, so back-to-back commands have no gap.
- SDA changes only while SCL=0, except within START and STOP.
- No combinational path from inputs to outputs.

## Structure
- Package `sccb_pkg` holds:
  - the state enum;
  - `SYM_WR`=30 and `SYM_RD`=42;
  - the phase/byte-select encoding;
  - the quarter-index type.
- Sub-module `sccb_tick_gen` (parameter `CLK_DIV`; inputs `clk`, `rst`, `clr`; outputs `tick`, `q[1:0]`) contains the divider.
- The FSM, shift registers and bit counter live in `sccb_master`.

## Test plan
- **Reset:** hold `rst`=0 for 5 cycles with `start`=1 → SCL=1, SDA=Z, no `load_comp`. Release → `load_comp` 1 cycle later.
- **Write:** `CLK_DIV`=4, `in_data`=16'h1280, `r_w`=0, ACKing slave model → SDA bytes 42,12,80 each followed by a released X bit. `task_comp` exactly 480 cycles after `load_comp`. `nack`=0.
- **Read:** `in_data`=16'h0A00, `r_w`=1, slave returns 8'h76 → bytes 42,0A, STOP, START, 43. NA bit is 1. `data_read`=8'h76 at `task_comp`, 672 cycles after `load_comp`.
- **No slave (SDA pulled high):** write 16'h1180 → full 480-cycle frame, `nack`=1 at `task_comp`. `nack` clears on the next acceptance.
- **Busy and back-to-back:** pulse `start` mid-frame → ignored. Hold `start`=1 continuously → second `load_comp` exactly 1 cycle after the first `task_comp`.
- **Reset mid-frame:** assert `rst` during the data byte → next cycle SCL=1, SDA=Z, no `task_comp`. A new `start` after release completes normally.
